// File: rtl/slurm16_cpu_decode_sb.sv
// SLURM16 decode/issue slot: holds one decoded instruction and issues it once none of its
// source or destination registers has a writeback still in flight (register scoreboard).
module slurm16_cpu_decode_sb #(
    parameter int BITS          = 16,
    parameter int REGISTER_BITS = 7,
    parameter int MAX_PENDING   = 4,
    localparam int CNT_BITS     = $clog2(MAX_PENDING + 1),
    localparam int NREGS        = 1 << REGISTER_BITS
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITS-1:0]          in_instr,
    input  logic [REGISTER_BITS-1:0] in_regA_sel,
    input  logic [REGISTER_BITS-1:0] in_regB_sel,
    input  logic                     in_wr_en,
    input  logic [REGISTER_BITS-1:0] in_wr_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS-1:0]          out_instr,
    output logic [REGISTER_BITS-1:0] out_regA_sel,
    output logic [REGISTER_BITS-1:0] out_regB_sel,
    output logic                     out_wr_en,
    output logic [REGISTER_BITS-1:0] out_wr_sel,
    output logic                     stall,
    input  logic                     flush,
    input  logic                     wb_valid,
    input  logic [REGISTER_BITS-1:0] wb_sel,
    output logic [CNT_BITS-1:0]      pending_cnt,
    output logic                     sb_error,
    output logic                     dbg_held
);

    // Handshake: a transfer occurs on a CLK edge where valid and ready are both high;
    // out_valid never looks at out_ready, and held fields only change on a transfer in.
    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_HELD = 1'b1} slot_state_t;

    slot_state_t          state, state_next;
    logic [NREGS-1:0]     pend, pend_eff, pend_next;
    logic [CNT_BITS-1:0]  cnt_eff, cnt_next;
    logic                 held, wb_hit, hazard, issue, load, set_en;
    logic                 haz_a, haz_b, haz_wr, at_capacity;

    assign held     = (state == SLOT_HELD);
    assign dbg_held = held;

    // A writeback landing this cycle already frees its register for the held instruction.
    always_comb begin
        pend_eff = pend;
        if (wb_valid) begin
            pend_eff[wb_sel] = 1'b0;
        end
    end

    assign wb_hit      = wb_valid & pend[wb_sel];
    assign cnt_eff     = pending_cnt - CNT_BITS'(wb_hit);
    assign at_capacity = (cnt_eff == CNT_BITS'(MAX_PENDING));

    assign haz_a  = (out_regA_sel != '0) & pend_eff[out_regA_sel];
    assign haz_b  = (out_regB_sel != '0) & pend_eff[out_regB_sel];
    assign haz_wr = out_wr_en & (out_wr_sel != '0) & (pend_eff[out_wr_sel] | at_capacity);
    assign hazard = held & (haz_a | haz_b | haz_wr);

    assign out_valid = held & ~hazard & ~flush;
    assign stall     = held & hazard;
    assign issue     = out_valid & out_ready;
    assign in_ready  = ~held | issue | flush;
    assign load      = in_valid & in_ready;
    assign set_en    = issue & out_wr_en & (out_wr_sel != '0);

    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next = SLOT_HELD;
                end
            end
            SLOT_HELD: begin
                if (load) begin
                    state_next = SLOT_HELD;
                end else if (issue || flush) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    // Setting the destination is applied after the clear so a same-register reissue keeps its bit.
    always_comb begin
        pend_next = pend;
        if (wb_valid) begin
            pend_next[wb_sel] = 1'b0;
        end
        if (set_en) begin
            pend_next[out_wr_sel] = 1'b1;
        end
    end

    always_comb begin
        cnt_next = pending_cnt;
        case ({set_en, wb_hit})
            2'b10: begin
                if (pending_cnt != CNT_BITS'(MAX_PENDING)) begin
                    cnt_next = pending_cnt + CNT_BITS'(1);
                end
            end
            2'b01: begin
                if (pending_cnt != '0) begin
                    cnt_next = pending_cnt - CNT_BITS'(1);
                end
            end
            default: cnt_next = pending_cnt;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state        <= SLOT_EMPTY;
            out_instr    <= '0;
            out_regA_sel <= '0;
            out_regB_sel <= '0;
            out_wr_en    <= 1'b0;
            out_wr_sel   <= '0;
            pend         <= '0;
            pending_cnt  <= '0;
            sb_error     <= 1'b0;
        end else begin
            state       <= state_next;
            pend        <= pend_next;
            pending_cnt <= cnt_next;
            if (load) begin
                out_instr    <= in_instr;
                out_regA_sel <= in_regA_sel;
                out_regB_sel <= in_regB_sel;
                out_wr_en    <= in_wr_en;
                out_wr_sel   <= in_wr_sel;
            end
            if (wb_valid && !pend[wb_sel]) begin
                sb_error <= 1'b1;
            end
        end
    end

endmodule
